// File: rtl/pipe_pkg.sv
// Shared pipeline package: packer FSM states and a lane-counter width helper.
package pipe_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pipe_pack_state_t;

  // Width of a counter that addresses RATIO lanes; never narrower than one bit.
  function automatic int lanes_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/pipe_width_packer.sv
// Packs RATIO narrow valid-ready beats into one wide word with a per-lane keep
// mask; i_last closes a partial word early. One register stage of latency.
module pipe_width_packer
  import pipe_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DWIDTH-1:0]       i_data,
  input  logic                    i_valid,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic [RATIO*DWIDTH-1:0] o_data,
  output logic [RATIO-1:0]        o_keep,
  output logic                    o_last,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int CNT_W = lanes_w(RATIO);
  localparam int WW    = RATIO * DWIDTH;

  pipe_pack_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WW-1:0]    acc_data, acc_data_nx;
  logic [RATIO-1:0] acc_keep, acc_keep_nx;
  logic             pend_last, pend_last_nx;
  logic             ready_rg, ready_nx;
  logic [WW-1:0]    out_data, out_data_nx;
  logic [RATIO-1:0] out_keep, out_keep_nx;
  logic             out_last, out_last_nx;
  logic             out_valid, out_valid_nx;

  logic             accept, out_free, word_close;
  logic [WW-1:0]    merge_data;
  logic [RATIO-1:0] merge_keep;

  assign accept     = i_valid & ready_rg;
  assign out_free   = ~out_valid | i_ready;
  assign word_close = accept & ((cnt == CNT_W'(RATIO - 1)) | i_last);

  always_comb begin
    // NOTE: every combinational output is given a default first so no latch is inferred.
    merge_data   = acc_data;
    merge_keep   = acc_keep | (RATIO'(1) << cnt);
    state_nx     = state;
    cnt_nx       = cnt;
    acc_data_nx  = acc_data;
    acc_keep_nx  = acc_keep;
    pend_last_nx = pend_last;
    ready_nx     = ready_rg;
    out_data_nx  = out_data;
    out_keep_nx  = out_keep;
    out_last_nx  = out_last;
    out_valid_nx = out_valid & ~i_ready;

    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_W'(k)) merge_data[k*DWIDTH +: DWIDTH] = i_data;
    end

    unique case (state)
      FILL: begin
        ready_nx = 1'b1;
        if (accept && !word_close) begin
          acc_data_nx = merge_data;
          acc_keep_nx = merge_keep;
          cnt_nx      = cnt + CNT_W'(1);
        end else if (word_close && out_free) begin
          // Load straight into the output register, overwriting a word leaving this edge.
          out_data_nx  = merge_data;
          out_keep_nx  = merge_keep;
          out_last_nx  = i_last;
          out_valid_nx = 1'b1;
          acc_data_nx  = '0;
          acc_keep_nx  = '0;
          cnt_nx       = '0;
        end else if (word_close) begin
          acc_data_nx  = merge_data;
          acc_keep_nx  = merge_keep;
          pend_last_nx = i_last;
          ready_nx     = 1'b0;
          state_nx     = HOLD;
        end
      end
      HOLD: begin
        ready_nx = 1'b0;
        if (out_free) begin
          out_data_nx  = acc_data;
          out_keep_nx  = acc_keep;
          out_last_nx  = pend_last;
          out_valid_nx = 1'b1;
          acc_data_nx  = '0;
          acc_keep_nx  = '0;
          cnt_nx       = '0;
          ready_nx     = 1'b1;
          state_nx     = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FILL;
      cnt       <= '0;
      acc_data  <= '0;
      acc_keep  <= '0;
      pend_last <= 1'b0;
      ready_rg  <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state     <= state_nx;
      cnt       <= cnt_nx;
      acc_data  <= acc_data_nx;
      acc_keep  <= acc_keep_nx;
      pend_last <= pend_last_nx;
      ready_rg  <= ready_nx;
      out_data  <= out_data_nx;
      out_keep  <= out_keep_nx;
      out_last  <= out_last_nx;
      out_valid <= out_valid_nx;
    end
  end

  assign o_ready = ready_rg;
  assign o_data  = out_data;
  assign o_keep  = out_keep;
  assign o_last  = out_last;
  assign o_valid = out_valid;

endmodule

// File: tb/tb_pipe_width_packer.sv
// Self-checking bench: directed scenarios on an 8x4 packer, randomised
// valid/ready on a 5x3 packer, both against a queue-based word model.
module tb_pipe_width_packer;

  localparam int DW_A = 8;
  localparam int R_A  = 4;
  localparam int DW_B = 5;
  localparam int R_B  = 3;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [DW_A-1:0]     a_i_data = '0;
  logic                a_i_valid = 1'b0, a_i_last = 1'b0, a_i_ready = 1'b0;
  logic                a_o_ready, a_o_last, a_o_valid;
  logic [R_A*DW_A-1:0] a_o_data;
  logic [R_A-1:0]      a_o_keep;

  logic [DW_B-1:0]     b_i_data = '0;
  logic                b_i_valid = 1'b0, b_i_last = 1'b0, b_i_ready = 1'b0;
  logic                b_o_ready, b_o_last, b_o_valid;
  logic [R_B*DW_B-1:0] b_o_data;
  logic [R_B-1:0]      b_o_keep;

  pipe_width_packer #(.DWIDTH(DW_A), .RATIO(R_A)) u_a (
    .clk(clk), .rstn(rstn), .i_data(a_i_data), .i_valid(a_i_valid), .i_last(a_i_last),
    .o_ready(a_o_ready), .o_data(a_o_data), .o_keep(a_o_keep), .o_last(a_o_last),
    .o_valid(a_o_valid), .i_ready(a_i_ready)
  );

  pipe_width_packer #(.DWIDTH(DW_B), .RATIO(R_B)) u_b (
    .clk(clk), .rstn(rstn), .i_data(b_i_data), .i_valid(b_i_valid), .i_last(b_i_last),
    .o_ready(b_o_ready), .o_data(b_o_data), .o_keep(b_o_keep), .o_last(b_o_last),
    .o_valid(b_o_valid), .i_ready(b_i_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  beat_t bq_a[$], bq_b[$];
  word_t exp_a[$], exp_b[$];
  word_t cur_a = '{default: '0}, cur_b = '{default: '0};
  int    n_a = 0, n_b = 0;

  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;
  logic [7:0]  prev_keep = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: beats fill lanes from 0 upward; a word is emitted when full or on last.
  task automatic push_beat(input bit is_b, input logic [7:0] d, input logic last);
    word_t w;
    int    n, dw, r;
    dw = is_b ? DW_B : DW_A;
    r  = is_b ? R_B : R_A;
    w  = is_b ? cur_b : cur_a;
    n  = is_b ? n_b : n_a;
    w.data = w.data | (64'(d) << (dw * n));
    w.keep = w.keep | (8'(1) << n);
    n++;
    if (n == r || last) begin
      w.last = last;
      if (is_b) exp_b.push_back(w); else exp_a.push_back(w);
      w = '{default: '0};
      n = 0;
    end
    if (is_b) begin
      cur_b = w; n_b = n; bq_b.push_back('{d, last});
    end else begin
      cur_a = w; n_a = n; bq_a.push_back('{d, last});
    end
  endtask

  task automatic model_reset_a();
    bq_a.delete();
    exp_a.delete();
    cur_a = '{default: '0};
    n_a = 0;
    prev_hold = 1'b0;
  endtask

  // One clock of the A channel: present the head beat, sample at the falling edge.
  task automatic cyc_a();
    logic  in_acc;
    word_t w;
    a_i_valid = (bq_a.size() > 0);
    if (bq_a.size() > 0) begin
      a_i_data = bq_a[0].data;
      a_i_last = bq_a[0].last;
    end else begin
      a_i_data = '0;
      a_i_last = 1'b0;
    end
    @(negedge clk);
    if (prev_hold) begin
      check("a_stable_data", 64'(a_o_data), prev_data);
      check("a_stable_keep", 64'(a_o_keep), 64'(prev_keep));
      check("a_stable_last", 64'(a_o_last), 64'(prev_last));
    end
    prev_hold = a_o_valid & ~a_i_ready;
    prev_data = 64'(a_o_data);
    prev_keep = 8'(a_o_keep);
    prev_last = a_o_last;
    in_acc = a_i_valid & a_o_ready;
    if (a_o_valid && a_i_ready) begin
      if (exp_a.size() == 0) begin
        check("a_spurious_word", 64'(a_o_data), 64'hdead);
      end else begin
        w = exp_a.pop_front();
        check("a_word_data", 64'(a_o_data), w.data);
        check("a_word_keep", 64'(a_o_keep), 64'(w.keep));
        check("a_word_last", 64'(a_o_last), 64'(w.last));
      end
    end
    @(posedge clk);
    #1;
    if (in_acc) void'(bq_a.pop_front());
  endtask

  task automatic feed_a(input int bound);
    int c = 0;
    while (bq_a.size() > 0 && c < bound) begin
      cyc_a();
      c++;
    end
    check("a_feed_timeout", 64'(bq_a.size()), 64'd0);
  endtask

  task automatic drain_a(input int bound);
    int c = 0;
    while ((bq_a.size() > 0 || exp_a.size() > 0) && c < bound) begin
      cyc_a();
      c++;
    end
    check("a_drain_timeout", 64'(bq_a.size() + exp_a.size()), 64'd0);
    check("a_idle_after_drain", 64'(a_o_valid), 64'd0);
  endtask

  initial begin
    word_t w;
    logic  in_acc;
    int    c;

    // Reset state and first rise of o_ready.
    a_i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_ready", 64'(a_o_ready), 64'd0);
    check("rst_o_valid", 64'(a_o_valid), 64'd0);
    check("rst_o_data", 64'(a_o_data), 64'd0);
    check("rst_o_keep", 64'(a_o_keep), 64'd0);
    check("rst_o_last", 64'(a_o_last), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(a_o_ready), 64'd1);

    // Full word, back-to-back.
    push_beat(0, 8'h11, 0); push_beat(0, 8'h22, 0);
    push_beat(0, 8'h33, 0); push_beat(0, 8'h44, 0);
    feed_a(20);
    check("full_latency_valid", 64'(a_o_valid), 64'd1);
    check("full_latency_data", 64'(a_o_data), 64'h44332211);
    drain_a(20);

    // Early close, then a full word must start again at lane 0.
    push_beat(0, 8'hAA, 0); push_beat(0, 8'hBB, 1);
    push_beat(0, 8'hC1, 0); push_beat(0, 8'hC2, 0);
    push_beat(0, 8'hC3, 0); push_beat(0, 8'hC4, 1);
    drain_a(30);

    // Single-beat packet: lane 0 only.
    push_beat(0, 8'h5A, 1);
    drain_a(10);

    // Backpressure into HOLD.
    a_i_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_beat(0, 8'(i), 0);
    feed_a(30);
    check("hold_ready_low", 64'(a_o_ready), 64'd0);
    check("hold_first_word", 64'(a_o_data), 64'h04030201);
    repeat (3) cyc_a();
    check("hold_ready_still_low", 64'(a_o_ready), 64'd0);
    a_i_ready = 1'b1;
    cyc_a();
    check("release_ready", 64'(a_o_ready), 64'd1);
    check("release_second_data", 64'(a_o_data), 64'h08070605);
    check("release_second_valid", 64'(a_o_valid), 64'd1);
    drain_a(20);

    // No bubble: a word closes every cycle while the previous one leaves.
    for (int i = 0; i < 6; i++) push_beat(0, 8'(8'hE0 + i), 1);
    repeat (7) cyc_a();
    check("no_bubble_words_left", 64'(exp_a.size()), 64'd0);
    check("no_bubble_ready", 64'(a_o_ready), 64'd1);
    drain_a(10);

    // Asynchronous reset mid-operation, with a word on the output and two beats buffered.
    a_i_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_beat(0, 8'(8'h30 + i), 0);
    feed_a(20);
    check("pre_reset_valid", 64'(a_o_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_o_valid", 64'(a_o_valid), 64'd0);
    check("mid_rst_o_data", 64'(a_o_data), 64'd0);
    check("mid_rst_o_keep", 64'(a_o_keep), 64'd0);
    check("mid_rst_o_ready", 64'(a_o_ready), 64'd0);
    model_reset_a();
    a_i_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    a_i_ready = 1'b1;
    push_beat(0, 8'h55, 0); push_beat(0, 8'h66, 0);
    push_beat(0, 8'h77, 0); push_beat(0, 8'h88, 0);
    drain_a(20);

    // Randomised valid/ready on the 5-bit x 3-lane instance.
    for (int i = 0; i < 240; i++)
      push_beat(1, 8'($urandom_range(31)), ($urandom_range(3) == 0));
    push_beat(1, 8'($urandom_range(31)), 1'b1);
    c = 0;
    while ((bq_b.size() > 0 || exp_b.size() > 0) && c < 4000) begin
      if (!b_i_valid && bq_b.size() > 0) b_i_valid = ($urandom_range(3) != 0);
      if (b_i_valid) begin
        b_i_data = bq_b[0].data[DW_B-1:0];
        b_i_last = bq_b[0].last;
      end
      b_i_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      in_acc = b_i_valid & b_o_ready;
      if (b_o_valid && b_i_ready) begin
        if (exp_b.size() == 0) begin
          check("b_spurious_word", 64'(b_o_data), 64'hdead);
        end else begin
          w = exp_b.pop_front();
          check("b_word_data", 64'(b_o_data), w.data);
          check("b_word_keep", 64'(b_o_keep), 64'(w.keep));
          check("b_word_last", 64'(b_o_last), 64'(w.last));
        end
      end
      @(posedge clk);
      #1;
      if (in_acc) begin
        void'(bq_b.pop_front());
        b_i_valid = 1'b0;
      end
      c++;
    end
    check("b_leftover", 64'(bq_b.size() + exp_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
